// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII TX arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, XFER, GAP)
//   FRAME_CNT_W  : width of each per-port completed-frame counter
//   GAP_CNT_W    : width of the inter-frame gap down-counter
package rgmii_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int GAP_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick (purely combinational).
// Scans the request vector starting at (last + 1) mod N and returns the
// first requester found.
//   req    : request vector, one bit per requester
//   last   : index of the previous winner
//   onehot : one-hot winner (all zero when nothing requests)
//   idx    : binary index of the winner
//   found  : high when any requester was selected
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    onehot   = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // k = N wraps back to 'last' itself, so the previous owner is lowest priority
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(last) + k) % N;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found            = 1'b1;
        onehot[cand_idx] = 1'b1;
        idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rgmii_tx_arbiter.sv
// Round-robin frame arbiter in front of the RGMII MAC transmit stream.
// A requester owns the MAC from grant until its tlast handshake; the
// data path is a zero-latency mux from the owner to the MAC.
//   clk, rst        : TX clock, synchronous active-high reset
//   s_axis_*        : NUM_PORTS requester streams (byte i at [8i+7:8i])
//   s_axis_tready   : per-requester ready (only the owner can see ready)
//   m_axis_*        : stream towards the MAC tx_axis interface
//   grant           : one-hot current owner, zero when no frame is in flight
//   frame_cnt       : completed frames per port, 16 bits each, wrapping
module rgmii_tx_arbiter
  import rgmii_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*8-1:0]           s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS-1:0]             s_axis_tuser,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [7:0]                       m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser,
  input  logic                             m_axis_tready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic [NUM_PORTS*FRAME_CNT_W-1:0] frame_cnt
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_t           state_reg;
  logic [NUM_PORTS-1:0] grant_reg;
  logic [IW-1:0]        owner_reg;
  logic [IW-1:0]        last_owner_reg;
  logic [GAP_CNT_W-1:0] gap_cnt_reg;

  logic [NUM_PORTS-1:0] pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic                 xfer;
  logic                 frame_done;

  rr_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr_pick (
    .req    (s_axis_tvalid),
    .last   (last_owner_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign xfer = (state_reg == XFER);

  // Owner's stream straight through to the MAC; nothing is driven outside XFER
  assign m_axis_tdata  = xfer ? s_axis_tdata[{owner_reg, 3'b000} +: 8] : 8'h00;
  assign m_axis_tvalid = xfer & s_axis_tvalid[owner_reg];
  assign m_axis_tlast  = xfer & s_axis_tlast[owner_reg];
  assign m_axis_tuser  = xfer & s_axis_tuser[owner_reg];

  assign frame_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign grant      = grant_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_ready
      assign s_axis_tready[gi] = xfer & grant_reg[gi] & m_axis_tready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IW'(NUM_PORTS - 1);
      gap_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg <= pick_onehot;
            owner_reg <= pick_idx;
            state_reg <= XFER;
          end
        end
        XFER: begin
          // Only the owner's final handshake releases the MAC
          if (frame_done) begin
            last_owner_reg <= owner_reg;
            grant_reg      <= '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt_reg <= GAP_CNT_W'(GAP_CYCLES);
              state_reg   <= GAP;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        GAP: begin
          // Counter starts at GAP_CYCLES, so GAP lasts exactly GAP_CYCLES cycles
          gap_cnt_reg <= gap_cnt_reg - 1'b1;
          if (gap_cnt_reg <= GAP_CNT_W'(1)) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_cnt
      logic [FRAME_CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (frame_done && (owner_reg == IW'(gi))) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign frame_cnt[gi*FRAME_CNT_W +: FRAME_CNT_W] = cnt_reg;
    end
  endgenerate

endmodule
